// File: rtl/comb_seq_ctrl.sv
// Exhaustive sequencer for a 3-input combinational block: steps A/B/C through all
// eight vectors, samples Q after a settle delay and compares against an expected table.
module comb_seq_ctrl #(
  parameter int unsigned SETTLE_CYC = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] exp_tt,
  input  logic       q,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_cnt,
  output logic [7:0] result
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [2:0] r_idx;
  logic [3:0] r_cnt;
  logic [7:0] r_exp;
  logic [2:0] r_abc;
  logic       r_busy;
  logic       r_done;
  logic       r_pass;
  logic [3:0] r_err_cnt;
  logic [7:0] r_result;

  logic       w_start_ok;
  logic       w_abort;
  logic       w_last_settle;
  logic [7:0] w_result_upd;
  logic [7:0] w_diff;
  logic [3:0] w_pop;

  assign w_start_ok    = (r_state == ST_IDLE) && start && !abort;
  assign w_abort       = ((r_state == ST_SETTLE) || (r_state == ST_SAMPLE)) && abort;
  assign w_last_settle = (r_cnt == 4'(SETTLE_CYC - 1));

  // Table including the bit being sampled this cycle, so pass/err_cnt land with done.
  always_comb begin
    w_result_upd        = r_result;
    w_result_upd[r_idx] = q;
    w_diff              = w_result_upd ^ r_exp;
    w_pop               = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      w_pop = w_pop + {3'b000, w_diff[i]};
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_start_ok) w_next = ST_SETTLE;
      ST_SETTLE: begin
        if (abort)              w_next = ST_IDLE;
        else if (w_last_settle) w_next = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        if (abort)              w_next = ST_IDLE;
        else if (r_idx == 3'd7) w_next = ST_DONE;
        else                    w_next = ST_SETTLE;
      end
      ST_DONE:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx     <= '0;
      r_cnt     <= '0;
      r_exp     <= '0;
      r_abc     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_pass    <= 1'b0;
      r_err_cnt <= '0;
      r_result  <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_abort) begin
        r_busy    <= 1'b0;
        r_abc     <= '0;
        r_idx     <= '0;
        r_cnt     <= '0;
        r_pass    <= 1'b0;
        r_err_cnt <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_start_ok) begin
              r_exp     <= exp_tt;
              r_idx     <= '0;
              r_cnt     <= '0;
              r_abc     <= '0;
              r_result  <= '0;
              r_pass    <= 1'b0;
              r_err_cnt <= '0;
              r_busy    <= 1'b1;
            end
          end
          ST_SETTLE: r_cnt <= r_cnt + 4'd1;
          ST_SAMPLE: begin
            r_result <= w_result_upd;
            if (r_idx == 3'd7) begin
              r_done    <= 1'b1;
              r_busy    <= 1'b0;
              r_pass    <= (w_diff == 8'h00);
              r_err_cnt <= w_pop;
              r_abc     <= '0;
              r_idx     <= '0;
            end else begin
              r_idx <= r_idx + 3'd1;
              r_abc <= r_idx + 3'd1;
              r_cnt <= '0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign {a, b, c} = r_abc;
  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign err_cnt   = r_err_cnt;
  assign result    = r_result;

endmodule

// File: tb/tb_comb_seq_ctrl.sv
// Self-checking bench for comb_seq_ctrl with a majority-function comb model;
// a second instance uses the minimum settle time.
module tb_comb_seq_ctrl;

  localparam int S0 = 2;
  localparam int S1 = 1;

  logic       clk = 1'b0;
  logic       rst, start, abort;
  logic [7:0] exp_tt;
  logic       a, b, c, busy, done, pass, q;
  logic [3:0] err_cnt;
  logic [7:0] result;
  logic       a1, b1, c1, busy1, done1, pass1, q1;
  logic [3:0] err_cnt1;
  logic [7:0] result1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  assign q  = (a & b) | (a & c) | (b & c);
  assign q1 = (a1 & b1) | (a1 & c1) | (b1 & c1);

  comb_seq_ctrl #(.SETTLE_CYC(S0)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .exp_tt(exp_tt), .q(q),
    .a(a), .b(b), .c(c), .busy(busy), .done(done), .pass(pass),
    .err_cnt(err_cnt), .result(result)
  );

  comb_seq_ctrl #(.SETTLE_CYC(S1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .exp_tt(exp_tt), .q(q1),
    .a(a1), .b(b1), .c(c1), .busy(busy1), .done(done1), .pass(pass1),
    .err_cnt(err_cnt1), .result(result1)
  );

  // Truth table of majority(A,B,C) with vector k = {A,B,C}.
  function automatic logic [7:0] maj_tt();
    logic [7:0] t;
    for (int k = 0; k < 8; k++) begin
      logic [2:0] v;
      v    = 3'(k);
      t[k] = ($countones(v) >= 2);
    end
    return t;
  endfunction

  function automatic int popc(input logic [7:0] v);
    int n;
    n = 0;
    for (int i = 0; i < 8; i++) n += int'(v[i]);
    return n;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_init();
    rst = 1'b1; start = 1'b0; abort = 1'b0; exp_tt = 8'h00;
    tick(); tick();
    rst = 1'b0;
    tick();
    tests++;
    if ({a, b, c, busy, done, pass, err_cnt, result} !== 17'h0) begin
      fails++;
      $display("FAIL reset_init: got %h expected 0", {a, b, c, busy, done, pass, err_cnt, result});
    end
  endtask

  task automatic test_run(input string name, input logic [7:0] exp, input bit pulse);
    logic [7:0] er;
    er = maj_tt();
    exp_tt = exp; start = 1'b1;
    tick();
    start = 1'b0;
    for (int j = 0; j < 8 * (S0 + 1); j++) begin
      tests++;
      if ({busy, done, a, b, c} !== {2'b10, 3'(j / (S0 + 1))}) begin
        fails++;
        $display("FAIL %s_seq[%0d]: got busy/done/abc=%b expected %b", name, j,
                 {busy, done, a, b, c}, {2'b10, 3'(j / (S0 + 1))});
      end
      start = pulse && ((j / (S0 + 1)) inside {2, 7}) && (j % (S0 + 1) == 1);
      tick();
    end
    start = 1'b0;
    tests++;
    if ({done, busy, a, b, c} !== 5'b10000) begin
      fails++;
      $display("FAIL %s_done: got done/busy/abc=%b expected 10000", name, {done, busy, a, b, c});
    end
    tests++;
    if (result !== er) begin
      fails++;
      $display("FAIL %s_result: got %h expected %h", name, result, er);
    end
    tests++;
    if (pass !== (er == exp)) begin
      fails++;
      $display("FAIL %s_pass: got %b expected %b", name, pass, (er == exp));
    end
    tests++;
    if (err_cnt !== 4'(popc(er ^ exp))) begin
      fails++;
      $display("FAIL %s_err_cnt: got %0d expected %0d", name, err_cnt, popc(er ^ exp));
    end
    tick();
    tests++;
    if ({done, busy, result, pass} !== {2'b00, er, (er == exp)}) begin
      fails++;
      $display("FAIL %s_after: got done/busy/result/pass=%h expected %h", name,
               {done, busy, result, pass}, {2'b00, er, (er == exp)});
    end
    tick();
  endtask

  task automatic test_abort_v4();
    logic [7:0] er;
    er = maj_tt();
    exp_tt = 8'hE8; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4 * (S0 + 1)) tick();
    tests++;
    if ({busy, a, b, c} !== 4'b1100) begin
      fails++;
      $display("FAIL abort_pre: got busy/abc=%b expected 1100", {busy, a, b, c});
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tests++;
    if ({busy, done, a, b, c, pass, err_cnt} !== 10'h0) begin
      fails++;
      $display("FAIL abort_state: got %b expected 0", {busy, done, a, b, c, pass, err_cnt});
    end
    tests++;
    if (result !== (er & 8'h0F)) begin
      fails++;
      $display("FAIL abort_result: got %h expected %h", result, er & 8'h0F);
    end
    for (int j = 0; j < 30; j++) begin
      if (done !== 1'b0) begin
        tests++; fails++;
        $display("FAIL abort_nodone: got done=1 at cycle %0d expected 0", j);
      end
      tick();
    end
    test_run("abort_rerun", 8'hE8, 1'b0);
  endtask

  task automatic test_random_abort(input int iters);
    logic [7:0] er, mask;
    int jab;
    er = maj_tt();
    for (int it = 0; it < iters; it++) begin
      jab = int'($urandom_range(0, 8 * (S0 + 1) - 1));
      mask = '0;
      for (int k = 0; k < 8; k++) if ((S0 + 1) * (k + 1) <= jab) mask[k] = 1'b1;
      exp_tt = 8'($urandom); start = 1'b1;
      tick();
      start = 1'b0;
      for (int j = 0; j < jab; j++) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      tests++;
      if ({busy, a, b, c, result, pass, err_cnt} !== {4'b0000, er & mask, 5'b00000}) begin
        fails++;
        $display("FAIL rnd_abort[%0d]: got %h expected %h", jab,
                 {busy, a, b, c, result, pass, err_cnt}, {4'b0000, er & mask, 5'b00000});
      end
      tick();
      tests++;
      if (done !== 1'b0) begin
        fails++;
        $display("FAIL rnd_abort_done[%0d]: got %b expected 0", jab, done);
      end
      repeat (20) tick();
    end
  endtask

  task automatic test_reset_midrun();
    exp_tt = 8'hE8; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5 * (S0 + 1) + 1) tick();
    tests++;
    if ({busy, a, b, c, result} !== {4'b1101, 8'h08}) begin
      fails++;
      $display("FAIL reset_pre: got %h expected %h", {busy, a, b, c, result}, {4'b1101, 8'h08});
    end
    #3 rst = 1'b1;
    #1;
    tests++;
    if ({a, b, c, busy, done, pass, err_cnt, result} !== 17'h0) begin
      fails++;
      $display("FAIL reset_async: got %h expected 0", {a, b, c, busy, done, pass, err_cnt, result});
    end
    tick();
    rst = 1'b0;
    repeat (4) tick();
    tests++;
    if ({busy, done, a, b, c} !== 5'b0) begin
      fails++;
      $display("FAIL reset_idle: got %b expected 0", {busy, done, a, b, c});
    end
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    tests++;
    if ({busy, a, b, c} !== 4'b0) begin
      fails++;
      $display("FAIL start_abort_idle: got %b expected 0", {busy, a, b, c});
    end
    tick();
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL start_abort_idle2: got %b expected 0", busy);
    end
    test_run("post_reset", 8'hE8, 1'b0);
  endtask

  task automatic test_settle1();
    logic [7:0] er;
    er = maj_tt();
    exp_tt = 8'hE8; start = 1'b1;
    tick();
    start = 1'b0;
    for (int j = 0; j < 8 * (S1 + 1); j++) begin
      tests++;
      if ({busy1, done1, a1, b1, c1} !== {2'b10, 3'(j / (S1 + 1))}) begin
        fails++;
        $display("FAIL settle1_seq[%0d]: got %b expected %b", j,
                 {busy1, done1, a1, b1, c1}, {2'b10, 3'(j / (S1 + 1))});
      end
      tick();
    end
    tests++;
    if ({done1, busy1, result1, pass1, err_cnt1} !== {2'b10, er, 1'b1, 4'd0}) begin
      fails++;
      $display("FAIL settle1_done: got %h expected %h",
               {done1, busy1, result1, pass1, err_cnt1}, {2'b10, er, 1'b1, 4'd0});
    end
    repeat (12) tick();
  endtask

  initial begin
    test_reset_init();
    test_run("majority", 8'hE8, 1'b0);
    test_run("all_wrong", 8'h17, 1'b0);
    test_run("one_wrong", 8'hE9, 1'b0);
    test_run("restart_ignored", 8'hE8, 1'b1);
    test_abort_v4();
    test_reset_midrun();
    test_settle1();
    for (int i = 0; i < 4; i++) test_run("random", 8'($urandom), 1'b0);
    test_random_abort(6);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/comb_seq_ctrl.md
Name: comb_seq_ctrl

Overview:
Sequencer that exhaustively exercises the 3-input combinational block `comb` (inputs A, B, C; output Q) in hardware. On a start request it drives all 8 input vectors in ascending order, waits a programmable settle time per vector, and samples Q to build an 8-bit truth table. At the end it compares the table against an expected table and reports pass/fail and the mismatch count. It sits between a host or test harness and one `comb` instance: its outputs a/b/c drive comb's A/B/C, and comb's Q feeds back on q.

Parameters:
SETTLE_CYC, 2, cycles each vector is held before Q is sampled (legal range 1..15).

Ports:
clk      in   1  rising-edge clock
rst      in   1  asynchronous, active-high reset
start    in   1  run request; sampled only in IDLE
abort    in   1  cancel the current run; sampled only while busy
exp_tt   in   8  expected truth table, bit k = expected Q for vector k; latched on accepted start
q        in   1  Q output of the driven comb instance
a        out  1  drives comb A (vector MSB)
b        out  1  drives comb B
c        out  1  drives comb C (vector LSB)
busy     out  1  high from the accepted start until DONE or abort
done     out  1  one-cycle pulse when a run completes
pass     out  1  result == latched exp_tt; valid when done pulses, held until the next accepted start
err_cnt  out  4  popcount(result ^ latched exp_tt), range 0..8; same validity as pass
result   out  8  captured truth table, bit k = Q sampled for vector k

Behaviour:
- Reset (asynchronous, takes effect immediately): state = IDLE; a = b = c = 0; busy = 0; done = 0; pass = 0; err_cnt = 0; result = 0; vector index = 0; settle counter = 0; latched expected table = 0.
- All outputs are registered. {a,b,c} always equals the 3-bit vector index while busy, and 0 in IDLE.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE, on start=1 and abort=0:
  - latch exp_tt; idx <= 0; cnt <= 0; result <= 0; pass <= 0; err_cnt <= 0; busy <= 1.
  - Next state is SETTLE.
  - If start=1 and abort=1 in the same cycle, stay in IDLE (abort wins).
- SETTLE: cnt increments each cycle. When cnt == SETTLE_CYC-1, go to SAMPLE. The vector is therefore stable for SETTLE_CYC cycles before sampling.
- SAMPLE (1 cycle): result[idx] <= q.
  - If idx == 7, go to DONE.
  - Otherwise idx <= idx+1; cnt <= 0; go to SETTLE.
- DONE (1 cycle):
  - done = 1; busy = 0.
  - pass and err_cnt are computed from the final result and registered so they are valid in this same cycle.
  - a/b/c return to 0. Next state is IDLE.
- Timing: with the start accepted at edge T0, vector k is sampled at edge T0 + (k+1)·(SETTLE_CYC+1). done is high in the cycle after edge T0 + 8·(SETTLE_CYC+1); with the default, that is edge T0+24.
- start while busy (SETTLE, SAMPLE or DONE): ignored, with no effect on the run.
- abort while in SETTLE or SAMPLE:
  - Next edge: state = IDLE, busy = 0, a/b/c = 0, idx = 0.
  - done is not pulsed; pass = 0 and err_cnt = 0.
  - result keeps the bits captured so far.
  - A SAMPLE cycle that coincides with abort does not write result.
- Boundary conditions:
  - idx never wraps during a run; 7 is terminal.
  - err_cnt reaches 8 only when every bit mismatches.
  - SETTLE_CYC = 1 gives 2 cycles per vector.

Test Plan:
1. Assert rst asynchronously mid-cycle → all outputs read 0 immediately; the block stays in IDLE after release with start=0.
2. Bench models comb as majority(A,B,C); start with exp_tt=8'hE8, default SETTLE_CYC → {a,b,c} steps 0..7, each held 3 cycles; done pulses for exactly 1 cycle at T0+24; result=8'hE8, pass=1, err_cnt=0.
3. Same model, exp_tt=8'h17 → result=8'hE8, pass=0, err_cnt=8. A rerun with exp_tt=8'hE9 → pass=0, err_cnt=1.
4. Pulse start again at vectors 2 and 7 of a run → no restart; sequence and done timing are identical to scenario 2; busy stays high continuously.
5. abort during SETTLE of vector 4 → next edge busy=0, a=b=c=0, no done pulse, result=8'h08 (bits 0..3 of 8'hE8); a new start then completes normally with pass=1.
6. Assert rst during vector 5, then release and start → the run begins at vector 0 and result/pass match scenario 2. Also apply start and abort together in IDLE → busy stays 0.
